// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel stream mux.
// Mode encodings and a constant-foldable ceil(log2).
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo NCH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_valid && req[SEL_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// NCH-to-1 valid/ready stream mux with fixed or round-robin select,
// a single registered output stage and a wrapping transfer counter.
module mux_n_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int CNT_W = 16,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     xfer_count
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load, fix_ok, grant_valid;
  logic             rr_gv, in_fire, out_fire;
  logic [SEL_W-1:0] rr_gi, grant_idx;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .grant_valid (rr_gv),
    .grant_idx   (rr_gi)
  );

  // out_ready only reaches in_ready through load, never the output regs
  always_comb begin
    load     = !out_valid_q || out_ready;
    fix_ok   = (int'(sel) < NCH) && in_valid[sel];
    if (mode == MODE_RR) begin
      grant_valid = rr_gv;
      grant_idx   = rr_gi;
    end else begin
      grant_valid = fix_ok;
      grant_idx   = sel;
    end
    in_fire  = load && grant_valid && rst_n;
    out_fire = out_valid_q && out_ready;
    in_ready = '0;
    if (in_fire) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    if (out_fire) begin
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      if (mode == MODE_RR) begin
        if (int'(grant_idx) == NCH - 1) rr_ptr_d = '0;
        else rr_ptr_d = grant_idx + SEL_W'(1);
      end
    end
    if (!rst_n) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_chan_d  = '0;
      rr_ptr_d    = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    out_valid_q <= out_valid_d;
    out_data_q  <= out_data_d;
    out_chan_q  <= out_chan_d;
    rr_ptr_q    <= rr_ptr_d;
    cnt_q       <= cnt_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// Scoreboard bench for mux_n_stream: driver pushes expected words,
// a negedge monitor pops and checks them plus the transfer count.
module tb_mux_n_stream;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;
  logic [3:0]  xfer_count;

  logic [7:0]  ch_data [4];
  logic [9:0]  exp_q [$];
  logic [3:0]  mcnt;
  int          n_chk;
  int          n_fail;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  mux_n_stream #(.WIDTH(8), .NCH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] er, input logic eov,
                      input logic push, input logic [1:0] ch,
                      input logic [7:0] d);
    @(negedge clk);
    chk("in_ready", 32'(er), 32'(in_ready));
    chk("out_valid", 32'(eov), 32'(out_valid));
    if (push) exp_q.push_back({ch, d});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented-and-accepted word, tracks count
  initial begin
    logic [9:0] e;
    mcnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mcnt = '0;
      end else begin
        chk("xfer_count", 32'(xfer_count), 32'(mcnt));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word got=%0h want=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_chan", 32'(out_chan), 32'(e[9:8]));
            chk("out_data", 32'(out_data), 32'(e[7:0]));
          end
          mcnt = mcnt + 4'd1;
        end
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ch_data[i] = 8'h10 + 8'(i);
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("rst_count", 32'(xfer_count), 32'd0);

    // Fixed select
    rst_n      = 1'b1;
    sel        = 2'd2;
    ch_data[2] = 8'hA5;
    in_valid   = 4'b0100;
    step(4'b0100, 1'b0, 1'b1, 2'd2, 8'hA5);
    sel = 2'd3;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
    in_valid = 4'b0000;
    step(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
    ch_data[2] = 8'h12;

    // Round-robin fairness
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++)
      step(4'b0001 << (i % 4), i > 0, 1'b1, 2'(i % 4), 8'h10 + 8'(i % 4));
    in_valid = 4'b0000;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);

    // Round-robin skip, ptr moved to 1 first
    in_valid = 4'b0001;
    step(4'b0001, 1'b0, 1'b1, 2'd0, 8'h10);
    in_valid = 4'b1001;
    step(4'b1000, 1'b1, 1'b1, 2'd3, 8'h13);
    step(4'b0001, 1'b1, 1'b1, 2'd0, 8'h10);
    step(4'b1000, 1'b1, 1'b1, 2'd3, 8'h13);
    in_valid = 4'b0000;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);

    // Backpressure
    in_valid = 4'b0001;
    step(4'b0001, 1'b0, 1'b1, 2'd0, 8'h10);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h10);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    step(4'b0010, 1'b1, 1'b1, 2'd1, 8'h11);
    in_valid = 4'b0000;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);

    // Reset with a held word discards it
    mode      = 1'b0;
    sel       = 2'd1;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    step(4'b0010, 1'b0, 1'b1, 2'd1, 8'h11);
    rst_n = 1'b0;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
    out_ready = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);

    // Counter wrap: 17 transfers on a 4-bit counter
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      step(4'b0010, i > 0, 1'b1, 2'd1, 8'h11);
    in_valid = 4'b0000;
    step(4'b0000, 1'b1, 1'b0, 2'd0, 8'h00);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("wrap_count", 32'(xfer_count), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_stream.md
Name: mux_n_stream

Overview:
- Parametrised successor to the team's 2:1 structural mux.
- Selects one of NCH input channels, each WIDTH bits wide with valid/ready handshake, onto a single registered output stream.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Sits between multiple adder/datapath result producers and a single shared consumer. Includes a wrapping transfer counter for debug and visibility.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- CNT_W, 16, transfer counter width.
- SEL_W (localparam), clog2(NCH), select width. Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low; sampled on rising clk.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  NCH  per-channel valid.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel ready; one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered output word.
- out_chan  out  SEL_W  source channel of out_data.
- out_ready  in  1  consumer accepts.
- xfer_count  out  CNT_W  count of completed output transfers; wraps.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0, xfer_count=0, rr_ptr=0.
  - in_ready forced to 0 while rst_n=0, combinationally.
- Accept condition: `load = !out_valid || out_ready` (single output stage; full throughput when consumer always ready).
- Grant, fixed mode (mode=0):
  - grant = sel if sel<NCH and in_valid[sel]; otherwise no grant.
  - sel>=NCH means no grant and no error.
- Grant, round-robin mode (mode=1):
  - Search channels rr_ptr, rr_ptr+1, ... wrapping modulo NCH.
  - First channel with in_valid=1 wins.
- in_ready[g] = load && grant_valid && rst_n. All other bits are 0.
- Input transfer: happens on channel g when in_valid[g] && in_ready[g] at a clk edge. Next cycle:
  - out_valid=1
  - out_data=in_data[g]
  - out_chan=g
- Latency: 1 cycle from input transfer to out_valid.
- Output transfer: happens when out_valid && out_ready at a clk edge.
  - xfer_count increments by 1, modulo 2^CNT_W.
  - If no input transfer happens in the same cycle, out_valid goes to 0.
- Simultaneous output and input transfer: out_valid stays 1, new data loads, counter increments. No bubble.
- Stall: out_valid=1 and out_ready=0 holds out_data and out_chan stable, and all in_ready=0.
- rr_ptr:
  - Updates only on an input transfer in mode 1, to (g+1) mod NCH.
  - Unchanged in mode 0 and when idle.
- Mode or sel change: takes effect on the same cycle's combinational grant. A word already in the output register is unaffected.
- Reset mid-operation: any held output word is discarded and not counted.
- No combinational path from out_ready to out_valid/out_data. The only combinational path from out_ready is to in_ready.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - clog2 function.
- One natural sub-module: rr_arbiter, parametrised by NCH.
  - Inputs: req, ptr.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
- The top holds the output register, the pointer and the counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=4'b1111.
  - Expect in_ready=0, out_valid=0, xfer_count=0.
  - Expect first out_valid one cycle after rst_n=1.
- Fixed mode: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
  - Expect in_ready=4'b0100, then out_data=8'hA5 and out_chan=2 the next cycle, then xfer_count=1.
  - Then sel=3 with in_valid[3]=0: expect in_ready=0.
- Round-robin fairness: mode=1, all in_valid=1, channel i data=8'h10+i, out_ready=1, 8 cycles.
  - Expect out_chan sequence 0,1,2,3,0,1,2,3.
  - Expect back-to-back out_valid and xfer_count=8.
- Round-robin skip: in_valid=4'b1001 with rr_ptr=1.
  - Expect grant ch3 first, then ch0, then ch3.
- Backpressure: out_ready=0 for 5 cycles with data loaded.
  - Expect out_data stable, in_ready=0, xfer_count unchanged.
  - Then out_ready=1: exactly one increment per transfer, with no data lost or duplicated.
- Counter wrap: CNT_W=4, 17 transfers → xfer_count=1.
